// File: rtl/tts_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tts_pkg
// Description : Shared state encoding and vector mapping helper for the
//               truth-table sweeper.
// Revision    : 1.0 - initial release
// ============================================================================
package tts_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int C_MAX_N_IN = 12;

    // Reflected Gray code of the low 'width' bits of value.
    function automatic logic [C_MAX_N_IN-1:0] bin2gray(
        input logic [C_MAX_N_IN-1:0] value,
        input int                    width
    );
        logic [C_MAX_N_IN-1:0] keep;
        keep = C_MAX_N_IN'((1 << width) - 1);
        return (value ^ (value >> 1)) & keep;
    endfunction

endpackage : tts_pkg
`default_nettype wire

// File: rtl/tts_vec_gen.sv
`default_nettype none
// ============================================================================
// Module      : tts_vec_gen
// Description : Vector index counter, settle-wait counter and binary/Gray
//               mapping for the truth-table sweeper.
// Revision    : 1.0 - initial release
// ============================================================================
module tts_vec_gen
    import tts_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1,
    parameter int GRAY   = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic            i_step,
    input  logic            i_count_en,
    output logic [N_IN-1:0] o_vec,
    output logic            o_settle_done,
    output logic            o_last
);

    logic [N_IN-1:0] r_idx;
    logic [3:0]      r_wait;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx  <= '0;
            r_wait <= '0;
        end else if (i_load) begin
            r_idx  <= '0;
            r_wait <= 4'(SETTLE);
        end else if (i_step) begin
            r_idx  <= r_idx + 1'b1;
            r_wait <= 4'(SETTLE);
        end else if (i_count_en && (r_wait != 4'd0)) begin
            r_wait <= r_wait - 4'd1;
        end
    end

    // High on the last APPLY cycle: the counter is about to reach zero.
    assign o_settle_done = (r_wait <= 4'd1);
    assign o_last        = &r_idx;

    generate
        if (GRAY != 0) begin : g_gray
            assign o_vec = N_IN'(bin2gray(C_MAX_N_IN'(r_idx), N_IN));
        end else begin : g_binary
            assign o_vec = r_idx;
        end
    endgenerate

endmodule : tts_vec_gen
`default_nettype wire

// File: rtl/truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_sweeper
// Description : Exhaustive reference-vs-minimized function checker with
//               don't-care masking and first-mismatch capture.
// Revision    : 1.0 - initial release
// ============================================================================
module truth_table_sweeper
    import tts_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1,
    parameter int GRAY   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2**N_IN-1:0]   dc_mask,
    input  logic                 f_ref,
    input  logic                 f_dut,
    output logic [N_IN-1:0]      vec_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_IN:0]        err_count,
    output logic                 err_valid,
    output logic [N_IN-1:0]      first_err
);

    localparam int NVEC = 2**N_IN;

    state_t            r_state;
    state_t            w_state_next;
    logic [NVEC-1:0]   r_mask;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic [N_IN:0]     r_err_count;
    logic              r_err_valid;
    logic [N_IN-1:0]   r_first_err;

    logic              w_load;
    logic              w_step;
    logic              w_count_en;
    logic              w_sample;
    logic              w_mismatch;
    logic [N_IN:0]     w_err_next;
    logic [N_IN-1:0]   w_vec;
    logic              w_settle_done;
    logic              w_last;

    tts_vec_gen #(
        .N_IN   (N_IN),
        .SETTLE (SETTLE),
        .GRAY   (GRAY)
    ) u_vec_gen (
        .clk           (clk),
        .rst           (rst),
        .i_load        (w_load),
        .i_step        (w_step),
        .i_count_en    (w_count_en),
        .o_vec         (w_vec),
        .o_settle_done (w_settle_done),
        .o_last        (w_last)
    );

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_count_en   = 1'b0;
        w_sample     = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = (SETTLE == 0) ? CHECK : APPLY;
                end
            end
            APPLY: begin
                w_count_en = 1'b1;
                if (w_settle_done) begin
                    w_state_next = CHECK;
                end
            end
            CHECK: begin
                w_sample = 1'b1;
                if (w_last) begin
                    w_state_next = DONE;
                end else begin
                    w_step       = 1'b1;
                    w_state_next = (SETTLE == 0) ? CHECK : APPLY;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // The mask is addressed by the applied vector, not by the sweep index.
    assign w_mismatch = w_sample && (f_ref != f_dut) && !r_mask[w_vec];
    assign w_err_next = r_err_count + {{N_IN{1'b0}}, w_mismatch};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_mask      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_count <= '0;
            r_err_valid <= 1'b0;
            r_first_err <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_mask      <= dc_mask;
                r_busy      <= 1'b1;
                r_done      <= 1'b0;
                r_pass      <= 1'b0;
                r_err_count <= '0;
                r_err_valid <= 1'b0;
                r_first_err <= '0;
            end else if (w_sample) begin
                r_err_count <= w_err_next;
                if (w_mismatch && !r_err_valid) begin
                    r_err_valid <= 1'b1;
                    r_first_err <= w_vec;
                end
                if (w_last) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    r_pass <= (w_err_next == '0);
                end
            end
        end
    end

    assign vec_out   = w_vec;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err_count;
    assign err_valid = r_err_valid;
    assign first_err = r_first_err;

endmodule : truth_table_sweeper
`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : tb_truth_table_sweeper
// Description : Scoreboard bench for truth_table_sweeper: binary, Gray and
//               zero-settle instances, masking, reset abort and restart.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_truth_table_sweeper;

    typedef struct {
        int         cycles;
        logic       pass;
        logic [4:0] cnt;
        logic       valid;
        logic [3:0] first;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] ref_tt = 16'hB4E1;

    logic        start_s     [3];
    logic [15:0] dc_s        [3];
    logic [15:0] inv_s       [3];
    logic        f_ref_s     [3];
    logic        f_dut_s     [3];
    logic [3:0]  vec_s       [3];
    logic        busy_s      [3];
    logic        done_s      [3];
    logic        pass_s      [3];
    logic [4:0]  err_count_s [3];
    logic        err_valid_s [3];
    logic [3:0]  first_err_s [3];

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];
    logic [3:0] vec_q[$];

    always #5 clk = ~clk;

    // Instance 0: binary SETTLE=1, 1: Gray SETTLE=1, 2: binary SETTLE=0.
    generate
        for (genvar i = 0; i < 3; i++) begin : g_dut
            localparam int S = (i == 2) ? 0 : 1;
            localparam int G = (i == 1) ? 1 : 0;
            assign f_ref_s[i] = ref_tt[vec_s[i]];
            assign f_dut_s[i] = ref_tt[vec_s[i]] ^ inv_s[i][vec_s[i]];
            truth_table_sweeper #(.N_IN(4), .SETTLE(S), .GRAY(G)) u_dut (
                .clk       (clk),
                .rst       (rst),
                .start     (start_s[i]),
                .dc_mask   (dc_s[i]),
                .f_ref     (f_ref_s[i]),
                .f_dut     (f_dut_s[i]),
                .vec_out   (vec_s[i]),
                .busy      (busy_s[i]),
                .done      (done_s[i]),
                .pass      (pass_s[i]),
                .err_count (err_count_s[i]),
                .err_valid (err_valid_s[i]),
                .first_err (first_err_s[i])
            );
        end
    endgenerate

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    // Gray-order monitor on instance 1: sequence, single-bit steps, capture point.
    logic [3:0] prev_g  = 4'd0;
    logic       prev_ev = 1'b0;
    always @(negedge clk) begin
        if (!rst && busy_s[1] && (vec_s[1] != prev_g)) begin
            if (vec_q.size() == 0) begin
                check("gray_extra_step", 32'(vec_s[1]), 32'hFFFF_FFFF);
            end else begin
                check("gray_seq", 32'(vec_s[1]), 32'(vec_q.pop_front()));
                check("gray_hamming", 32'($countones(vec_s[1] ^ prev_g)), 32'd1);
            end
        end
        if (!rst && err_valid_s[1] && !prev_ev) begin
            check("gray_capture_point", 32'(vec_s[1]), 32'd6);
        end
        prev_g  = vec_s[1];
        prev_ev = err_valid_s[1];
    end

    task automatic sweep(input int k, input logic [15:0] inv, input logic [15:0] dc,
                         input int glitch_at);
        exp_t e;
        exp_t got;
        int   cyc;
        logic [3:0] v;
        e.cycles = 16 * ((k == 2) ? 1 : 2);
        e.cnt    = 5'd0;
        e.valid  = 1'b0;
        e.first  = 4'd0;
        for (int i = 0; i < 16; i++) begin
            v = (k == 1) ? 4'(i ^ (i >> 1)) : 4'(i);
            if (k == 1 && i > 0) vec_q.push_back(v);
            if (inv[v] && !dc[v]) begin
                if (!e.valid) e.first = v;
                e.valid = 1'b1;
                e.cnt   = e.cnt + 5'd1;
            end
        end
        e.pass = (e.cnt == 5'd0);
        exp_q.push_back(e);

        inv_s[k]   = inv;
        dc_s[k]    = dc;
        start_s[k] = 1'b1;
        @(posedge clk); #1;
        start_s[k] = 1'b0;
        check("busy_after_start", 32'(busy_s[k]), 32'd1);
        check("done_clr_on_start", 32'(done_s[k]), 32'd0);
        cyc = 0;
        while (!done_s[k] && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            start_s[k] = (cyc == glitch_at);
            if (cyc == glitch_at) dc_s[k] = ~dc;
        end
        start_s[k] = 1'b0;
        got.cycles = cyc;
        got.pass   = pass_s[k];
        got.cnt    = err_count_s[k];
        got.valid  = err_valid_s[k];
        got.first  = first_err_s[k];
        e = exp_q.pop_front();
        check("sweep_cycles", 32'(got.cycles), 32'(e.cycles));
        check("pass", 32'(got.pass), 32'(e.pass));
        check("err_count", 32'(got.cnt), 32'(e.cnt));
        check("err_valid", 32'(got.valid), 32'(e.valid));
        if (e.valid) check("first_err", 32'(got.first), 32'(e.first));
        check("busy_clr_at_done", 32'(busy_s[k]), 32'd0);
        @(posedge clk); #1;
        check("done_held", 32'(done_s[k]), 32'd1);
    endtask

    task automatic check_cleared(input int k, input string tag);
        check({tag, "_vec"},       32'(vec_s[k]), 32'd0);
        check({tag, "_busy"},      32'(busy_s[k]), 32'd0);
        check({tag, "_done"},      32'(done_s[k]), 32'd0);
        check({tag, "_pass"},      32'(pass_s[k]), 32'd0);
        check({tag, "_err_count"}, 32'(err_count_s[k]), 32'd0);
        check({tag, "_err_valid"}, 32'(err_valid_s[k]), 32'd0);
        check({tag, "_first_err"}, 32'(first_err_s[k]), 32'd0);
    endtask

    initial begin
        int cyc;
        for (int k = 0; k < 3; k++) begin
            start_s[k] = 1'b0;
            dc_s[k]    = 16'h0;
            inv_s[k]   = 16'h0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_cleared(0, "reset");
        rst = 1'b0;

        sweep(0, 16'h0000, 16'h0000, -1);
        sweep(0, 16'h0408, 16'h0000, -1);
        sweep(0, 16'h0408, 16'h0408, -1);
        sweep(0, 16'h0008, 16'h0400, -1);

        // Abort mid-sweep once vector 7 is on the bus.
        inv_s[0]   = 16'h0408;
        start_s[0] = 1'b1;
        @(posedge clk); #1;
        start_s[0] = 1'b0;
        cyc = 0;
        while (vec_s[0] != 4'd7 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("reach_vec7", 32'(vec_s[0]), 32'd7);
        rst = 1'b1;
        @(posedge clk); #1;
        check_cleared(0, "abort");
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_after_abort_busy", 32'(busy_s[0]), 32'd0);
        sweep(0, 16'h0000, 16'h0000, -1);

        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sweep(1, 16'h0004, 16'h0000, -1);
        check("gray_seq_consumed", 32'(vec_q.size()), 32'd0);

        sweep(2, 16'h0408, 16'h0000, 5);
        sweep(2, 16'hFFFF, 16'h0000, -1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_truth_table_sweeper
`default_nettype wire

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Self-running exhaustive checker for N_IN-input combinational functions.
- Drives every input vector to a reference function and a minimized function (the DUT) and compares their outputs.
- Minterms flagged in a don't-care mask are excluded from the comparison.
- Replaces hand-written 2**N vector lists in benches; it is synthesizable so the same check can run on the board.

Parameters:
- N_IN, 4, number of function inputs (1..12); the sweep covers 2**N_IN vectors.
- SETTLE, 1, wait cycles between applying a vector and sampling the outputs (0..15).
- GRAY, 0, vector order: 0 = ascending binary, 1 = reflected Gray code.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle request to begin a sweep.
- dc_mask  in  2**N_IN  bit m=1 means minterm m is don't-care; captured at sweep start.
- f_ref  in  1  reference function output.
- f_dut  in  1  minimized function output.
- vec_out  out  N_IN  current input vector applied to both functions.
- busy  out  1  sweep in progress.
- done  out  1  sweep finished; held until the next start or rst.
- pass  out  1  done and no counted mismatch.
- err_count  out  N_IN+1  number of non-don't-care mismatches.
- err_valid  out  1  at least one mismatch has been captured.
- first_err  out  N_IN  minterm (vec_out value) of the first mismatch.

Behaviour:
- Reset: when rst=1 at a clock edge, all outputs clear to 0, state goes to IDLE and the internal mask register clears. rst has priority over start at all times.
- States: IDLE, APPLY, CHECK, DONE.
- IDLE or DONE with start=1:
  - Clear err_count, err_valid and first_err; latch dc_mask.
  - Set idx=0, vec_out=map(0), wait counter=SETTLE, busy=1, done=0, pass=0.
  - Next state is APPLY, or CHECK if SETTLE=0.
- APPLY: decrement the wait counter each cycle; go to CHECK on the cycle the counter reaches 0. vec_out is held stable.
- CHECK: sample f_ref and f_dut for one cycle.
  - A mismatch is counted when f_ref != f_dut and mask[vec_out]=0. Note the mask is indexed by the vector value, not by idx.
  - On a counted mismatch: err_count increments. If err_valid was 0, first_err takes vec_out and err_valid goes to 1.
  - If idx = 2**N_IN-1: go to DONE, busy=0, done=1, pass=(final err_count==0).
  - Otherwise: idx+1, vec_out=map(idx+1), reload the wait counter, go to APPLY (or CHECK if SETTLE=0).
- map(i) = i when GRAY=0; i ^ (i>>1) when GRAY=1. In Gray mode consecutive vectors differ in exactly one bit.
- Timing: each vector costs SETTLE+1 cycles. From start accepted to done=1 is 2**N_IN*(SETTLE+1) cycles; N_IN=4, SETTLE=1 gives 32.
- err_count width N_IN+1 holds up to 2**N_IN, so it never wraps and needs no saturation.
- start while busy is ignored.
- Changes on dc_mask during a sweep have no effect.
- rst mid-sweep aborts immediately; no partial result is kept.
- vec_out stays at the last vector while in DONE.
- f_ref and f_dut are assumed settled within SETTLE cycles; the block adds no synchronizers.

Decomposition:
- Package tts_pkg:
  - state enum {IDLE, APPLY, CHECK, DONE};
  - function bin2gray(value, width);
  - localparam NVEC = 2**N_IN, computed in the module from N_IN.
- Sub-module tts_vec_gen: idx counter, SETTLE wait counter and the binary/Gray mapping. Outputs vec_out, a sample strobe and a last flag.
- Compare, capture and FSM logic stay in truth_table_sweeper.

Test Plan:
- N_IN=4, SETTLE=1, f_dut identical to f_ref, dc_mask=0, start -> done=1 exactly 32 cycles after start; pass=1, err_count=0, err_valid=0.
- f_dut inverts f_ref at minterms 3 and 10, dc_mask=0 -> err_count=2, first_err=3, err_valid=1, pass=0.
- Same as the previous case with dc_mask bits 3 and 10 set -> err_count=0, pass=1. Mismatch at 3 with only bit 10 masked -> err_count=1, first_err=3.
- GRAY=1, mismatch at minterm 2 -> vec_out sequence 0,1,3,2,6,7,5,4,...; every step has Hamming distance 1; first_err=2, captured on the 4th CHECK.
- rst pulsed while vec_out=7 -> next cycle all outputs 0 and state IDLE. A later start runs a full fresh 32-cycle sweep; no stale err_count.
- SETTLE=0: sweep takes 16 cycles. start pulsed while busy -> no effect. start pulsed in DONE -> counters clear and a new sweep begins.
